// File: rtl/conv_core_param.sv
// KSIZE x KSIZE convolution engine: unsigned pixels, signed programmable coefficients, 3-stage pipeline.
// Optional output clamping to [0, 2^DW-1] with an overflow flag is enabled by defining CONV_SAT_EN.
module conv_core_param #(
   parameter  int DW    = 32,
   parameter  int CW    = 8,
   parameter  int KSIZE = 3,
   parameter  int SHW   = 5,
   localparam int TAPS  = KSIZE * KSIZE,
   localparam int ADRW  = $clog2(TAPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [TAPS*DW-1:0]   pix_in,
   input  logic                 coef_we,
   input  logic [ADRW-1:0]      coef_addr,
   input  logic [CW-1:0]        coef_wdata,
   input  logic [SHW-1:0]       shift,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [DW-1:0]        result,
   output logic                 ovf
);

   localparam int PW = DW + CW + 1;
   localparam int AW = PW + $clog2(TAPS);
   localparam logic [ADRW:0] TAPS_L = (ADRW + 1)'(TAPS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_SUM,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic signed [CW-1:0]  coef_q [TAPS];
   logic signed [PW-1:0]  prod_q [TAPS];
   logic signed [PW-1:0]  prod_d [TAPS];
   logic signed [AW-1:0]  row_q  [KSIZE];
   logic signed [AW-1:0]  row_d  [KSIZE];
   logic [DW-1:0]         result_q, result_d;
   logic                  ovf_q, ovf_d;
   logic                  load_prod, load_row;
   logic signed [AW-1:0]  acc;
   logic signed [AW-1:0]  shifted;
   logic [DW-1:0]         out_res;
   logic                  out_ovf;

   // Pixel zero-extended and coefficient sign-extended to the full product width.
   always_comb begin
      for (int unsigned i = 0; i < TAPS; i++) begin
         prod_d[i] = $signed({{(CW + 1){1'b0}}, pix_in[i*DW +: DW]}) *
                     $signed({{(DW + 1){coef_q[i][CW-1]}}, coef_q[i]});
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < KSIZE; r++) begin
         row_d[r] = '0;
         for (int unsigned c = 0; c < KSIZE; c++) begin
            row_d[r] = row_d[r] +
                       {{(AW - PW){prod_q[r*KSIZE + c][PW-1]}}, prod_q[r*KSIZE + c]};
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int unsigned r = 0; r < KSIZE; r++) begin
         acc = acc + row_q[r];
      end
      shifted = acc >>> shift;
   end

`ifdef CONV_SAT_EN
   always_comb begin
      out_res = shifted[DW-1:0];
      out_ovf = 1'b0;
      if (shifted[AW-1]) begin
         out_res = '0;
         out_ovf = 1'b1;
      end else if (|shifted[AW-1:DW]) begin
         out_res = '1;
         out_ovf = 1'b1;
      end
   end
`else
   logic unused_hi;
   assign unused_hi = ^shifted[AW-1:DW];
   assign out_res   = shifted[DW-1:0];
   assign out_ovf   = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      load_prod = 1'b0;
      load_row  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load_prod = 1'b1;
               state_d   = S_MUL;
            end
         end
         S_MUL: begin
            if (start) begin
               load_row = 1'b1;
               state_d  = S_SUM;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_SUM: begin
            if (start) begin
               result_d = out_res;
               ovf_d    = out_ovf;
               state_d  = S_DONE;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_DONE: begin
            if (!start) begin
               ovf_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         result_q <= '1;
         ovf_q    <= 1'b0;
         for (int unsigned i = 0; i < TAPS; i++) begin
            coef_q[i] <= CW'(i + 1);
            prod_q[i] <= '0;
         end
         for (int unsigned r = 0; r < KSIZE; r++) begin
            row_q[r] <= '0;
         end
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         // Products latch the pre-write coefficient when a write coincides with start.
         if (coef_we && ({1'b0, coef_addr} < TAPS_L)) begin
            coef_q[coef_addr] <= coef_wdata;
         end
         if (load_prod) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
               prod_q[i] <= prod_d[i];
            end
         end
         if (load_row) begin
            for (int unsigned r = 0; r < KSIZE; r++) begin
               row_q[r] <= row_d[r];
            end
         end
      end
   end

   assign busy   = (state_q == S_MUL) || (state_q == S_SUM);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_conv_core_param.sv
// Self-checking bench for conv_core_param: directed table, hand-written corner sequences, random runs.
// Expected values follow CONV_SAT_EN when the bench is compiled with that macro.
module tb_conv_core_param;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int KSIZE = 3;
   localparam int SHW = 5;
   localparam int TAPS = KSIZE * KSIZE;

   logic                 clk;
   logic                 reset;
   logic [TAPS*DW-1:0]   pix_in;
   logic                 coef_we;
   logic [3:0]           coef_addr;
   logic [CW-1:0]        coef_wdata;
   logic [SHW-1:0]       shift;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [DW-1:0]        result;
   logic                 ovf;

   conv_core_param #(.DW(DW), .CW(CW), .KSIZE(KSIZE), .SHW(SHW)) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_in     (pix_in),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .shift      (shift),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   longint mpix  [TAPS];
   int     mcoef [TAPS];

   typedef struct {
      int          pixv;
      int          mode;
      int          sh;
      logic [31:0] er;
      logic        eo;
   } vec_t;

`ifdef CONV_SAT_EN
   localparam logic [31:0] NEG9_RES = 32'h0;
   localparam logic        NEG9_OVF = 1'b1;
`else
   localparam logic [31:0] NEG9_RES = 32'hFFFF_FFF7;
   localparam logic        NEG9_OVF = 1'b0;
`endif

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Plain-arithmetic reference: dot product, arithmetic shift, then wrap or clamp.
   function automatic logic [32:0] model(input int sh);
      longint acc = 0;
      longint s;
      logic [63:0] sv;
      for (int i = 0; i < TAPS; i++) acc += mpix[i] * longint'(mcoef[i]);
      s = acc >>> sh;
      sv = s;
`ifdef CONV_SAT_EN
      if (s < 0) return {1'b1, 32'h0};
      if (s > 64'sh0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
      return {1'b0, sv[31:0]};
`else
      return {1'b0, sv[31:0]};
`endif
   endfunction

   task automatic drive_pix();
      for (int i = 0; i < TAPS; i++) pix_in[i*DW +: DW] = mpix[i][31:0];
   endtask

   task automatic set_pix_all(input longint v);
      for (int i = 0; i < TAPS; i++) mpix[i] = v;
   endtask

   task automatic wr_coef(input int addr, input logic [7:0] data);
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = 4'(addr);
      coef_wdata = data;
      @(negedge clk);
      coef_we    = 1'b0;
      if (addr < TAPS) mcoef[addr] = int'($signed(data));
   endtask

   task automatic reset_model_coefs();
      for (int i = 0; i < TAPS; i++) mcoef[i] = i + 1;
   endtask

   // Full transaction: checks busy for exactly two cycles, done on the third edge, then release.
   task automatic run(input string nm, input logic [31:0] er, input logic eo);
      logic [31:0] prev;
      @(negedge clk);
      drive_pix();
      prev  = result;
      start = 1'b1;
      @(posedge clk); #1;
      chk({nm, "/busy1"}, busy, 1);
      chk({nm, "/done1"}, done, 0);
      for (int i = 0; i < TAPS; i++) pix_in[i*DW +: DW] = $urandom();
      @(posedge clk); #1;
      chk({nm, "/busy2"}, busy, 1);
      chk({nm, "/hold2"}, result, prev);
      @(posedge clk); #1;
      chk({nm, "/done3"}, done, 1);
      chk({nm, "/busy3"}, busy, 0);
      chk({nm, "/result"}, result, er);
      chk({nm, "/ovf"}, ovf, eo);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk({nm, "/done_clr"}, done, 0);
      chk({nm, "/res_keep"}, result, er);
      chk({nm, "/ovf_clr"}, ovf, 0);
   endtask

   vec_t vecs [4];
   logic [32:0] m;
   logic [31:0] last_res;
   logic [31:0] e_old;

   initial begin
      reset = 1'b0; start = 1'b0; coef_we = 1'b0; coef_addr = '0;
      coef_wdata = '0; shift = '0; pix_in = '0;
      reset_model_coefs();
      set_pix_all(1);

      vecs[0] = '{1,  0, 0, 32'd45,   1'b0};
      vecs[1] = '{10, 1, 0, 32'd390,  1'b0};
      vecs[2] = '{1,  0, 2, 32'd11,   1'b0};
      vecs[3] = '{1,  2, 0, NEG9_RES, NEG9_OVF};

      #12;
      chk("rst/busy", busy, 0);
      chk("rst/done", done, 0);
      chk("rst/result", result, 32'hFFFF_FFFF);
      chk("rst/ovf", ovf, 0);
      @(negedge clk);
      reset = 1'b1;

      run("defaults", 32'd45, 1'b0);

      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < TAPS; i++) begin
            if (vecs[v].mode == 2) wr_coef(i, 8'hFF);
            else if (vecs[v].mode == 1 && i == 4) wr_coef(i, 8'hFF);
            else wr_coef(i, 8'(i + 1));
         end
         set_pix_all(vecs[v].pixv);
         shift = 5'(vecs[v].sh);
         run($sformatf("vec%0d", v), vecs[v].er, vecs[v].eo);
      end
      last_res = result;

      // Abort in SUM and in MUL: result and done must not move.
      for (int i = 0; i < TAPS; i++) wr_coef(i, 8'(i + 1));
      set_pix_all(7);
      shift = '0;
      @(negedge clk); drive_pix(); start = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("abort_sum/done", done, 0);
         chk("abort_sum/result", result, last_res);
      end
      chk("abort_sum/busy", busy, 0);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk("abort_mul/busy", busy, 0);
      chk("abort_mul/result", result, last_res);

      // Coefficient write coinciding with the start edge.
      set_pix_all(1);
      m = model(0);
      e_old = m[31:0];
      @(negedge clk);
      drive_pix(); start = 1'b1;
      coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 8'd100;
      @(posedge clk); #1;
      @(negedge clk); coef_we = 1'b0;
      mcoef[0] = 100;
      @(posedge clk); @(posedge clk); #1;
      chk("wr_on_start/done", done, 1);
      chk("wr_on_start/result", result, e_old);
      @(negedge clk); start = 1'b0;
      @(posedge clk);
      m = model(0);
      run("wr_on_start/new", m[31:0], m[32]);
      chk("new_coef_val", result, 32'd144);

      // Random transactions, including ignored out-of-range coefficient addresses.
      for (int t = 0; t < 40; t++) begin
         int nw;
         nw = int'($urandom_range(0, 3));
         for (int w = 0; w < nw; w++) wr_coef(int'($urandom_range(0, 15)), 8'($urandom()));
         for (int i = 0; i < TAPS; i++)
            mpix[i] = (t % 2 == 0) ? longint'($urandom_range(0, 255)) : longint'($urandom());
         shift = (t % 5 == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         m = model(int'(shift));
         run($sformatf("rand%0d", t), m[31:0], m[32]);
      end

      // Asynchronous reset between the MUL and SUM edges.
      set_pix_all(3);
      @(negedge clk); drive_pix(); start = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("async_rst/done", done, 0);
      chk("async_rst/busy", busy, 0);
      chk("async_rst/result", result, 32'hFFFF_FFFF);
      chk("async_rst/ovf", ovf, 0);
      @(negedge clk);
      start = 1'b0; reset = 1'b1; shift = '0;
      reset_model_coefs();
      set_pix_all(1);
      run("after_rst", 32'd45, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/conv_core_param.md
Name: conv_core_param

Overview:
Parametrised successor to the fixed 3x3 convolution engine in the Qsys pixel path. It computes a KSIZE x KSIZE dot product of unsigned pixels with signed, run-time-programmable coefficients through a fixed 3-stage pipeline. An arithmetic right shift scales the result. Same level start/done handshake as the existing core, so it drops into the same controller.

Parameters:
DW, 32, pixel and result width (bits)
CW, 8, coefficient width, signed two's complement
KSIZE, 3, kernel edge; TAPS = KSIZE*KSIZE (range 2..5)
SHW, 5, width of shift control

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk)
pix_in  in  TAPS*DW  flattened pixels; tap i = pix_in[i*DW +: DW]; row-major, tap 0 top-left
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  coefficient index
coef_wdata  in  CW  coefficient value
shift  in  SHW  arithmetic right-shift applied to the final sum
start  in  1  level request; held high until done is seen
busy  out  1  high in MUL and SUM states
done  out  1  result valid; held until start falls
result  out  DW  scaled convolution result
ovf  out  1  saturation occurred on the last result (CONV_SAT_EN only)

Behaviour:
- Reset values:
  - state=IDLE, busy=0, done=0, ovf=0, result={DW{1'b1}}.
  - coef[i]=i+1, so tap 0..8 hold 1..9, matching the legacy kernel.
  - Product and row-sum registers are cleared to 0.
- Internal widths: each product is DW+CW+1 bits signed (pixel zero-extended). Accumulator AW = DW+CW+1+clog2(TAPS), signed; no internal overflow is possible.
- Coefficient writes:
  - Accepted on any cycle when coef_we=1; coef_addr >= TAPS is ignored.
  - A write on the same edge that start is accepted does not affect that computation (old value used).
- FSM:
  - IDLE: start=1 -> register all TAPS products from current pix_in/coef; go to MUL; busy=1.
  - MUL: start=1 -> register KSIZE row sums; go to SUM. start=0 -> abort to IDLE; busy=0; result/done unchanged.
  - SUM: start=1 -> result <= out(sum of row sums >>> shift); done=1; busy=0; go to DONE. start=0 -> abort to IDLE as above.
  - DONE: hold result and done while start=1. start=0 -> done=0; go to IDLE.
  - Restart requires at least one cycle with start=0.
- Latency: start first sampled high at edge k -> done and result valid after edge k+2 (3 cycles). The result register changes only on that edge.
- pix_in is sampled only at edge k; later changes do not affect the result.
- Output mapping (no macro): result = low DW bits of the shifted accumulator (two's complement wrap); ovf stays 0.
- shift >= AW yields 0 for a non-negative accumulator and all ones for a negative one.
- Reset asserted mid-operation: immediate return to reset values, including coefficients.

Optional Feature:
CONV_SAT_EN
- Defined: the shifted accumulator is clamped to unsigned [0, 2^DW-1]. Negative gives 0, too large gives all ones. ovf=1 registered with result when a clamp occurs, else 0; ovf is cleared to 0 on IDLE entry from DONE.
- Undefined: wrap behaviour as above; ovf tied 0.

Test Plan:
1. Reset release, defaults, all pixels=1, shift=0, start held -> done rises 3 cycles after start, result=45, busy high exactly 2 cycles.
2. Write coef[4]=-1 (0xFF), all pixels=10, shift=0 -> result=390.
3. Defaults, all pixels=1, shift=2 -> result=11. Then drop start -> done=0 next edge, result stays 11.
4. All coefs=-1, pixels=1 -> result=0xFFFFFFF7, ovf=0 without macro; result=0, ovf=1 with CONV_SAT_EN.
5. Start high 2 cycles then low (abort in SUM) -> done never rises, result keeps its previous value. Also write coef on the start edge -> old coef used, new coef used on the next run.
6. Assert reset between the MUL and SUM edges -> done=0, busy=0 and result=0xFFFFFFFF immediately without a clock edge; coefs back to 1..9.
